vx_csr_bank: RTL and testbench
==============================

# vx_csr_bank

Per-core CSR bank for Vortex: a parametrised, pipelined successor to the per-core CSR data store. It serves atomic CSR read-modify-write requests from the CSR unit over a valid/ready handshake with a registered response. It holds per-warp fcsr and mscratch plus configurable-width cycle/instret counters, and merges FPU fflags accumulation with software writes without losing flags. It sits between VX_csr_unit and the FPU/commit stages.

## Interface
- CORE_ID, 0, global core index for GCID/GWID/GTID.
- NUM_WARPS, `NUM_WARPS, warps served; wid width NWB = max(1, $clog2(NUM_WARPS)).
- CTR_WIDTH, 64, cycle/instret width, legal 32..64.
- CMT_WIDTH, $clog2(`NUM_THREADS+1), width of commit_size.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_wid  in  NWB  requesting warp.
- req_addr  in  `CSR_ADDR_BITS  CSR address.
- req_op  in  2  0 = read, 1 = RW, 2 = RS (set), 3 = RC (clear).
- req_data  in  32  write data or mask.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_wid  out  NWB  warp of the response.
- rsp_data  out  32  CSR value before modification.
- rsp_err  out  1  illegal address or illegal write.
- fpu_wr_valid  in  1  fflags accumulate strobe.
- fpu_wr_wid  in  NWB  warp for fflags.
- fpu_fflags  in  `FFG_BITS  flags to OR in.
- fpu_rd_wid  in  NWB  warp for rounding-mode lookup.
- fpu_frm  out  `FRM_BITS  combinational frm of fpu_rd_wid.
- cmt_valid  in  1  commit strobe.
- cmt_size  in  CMT_WIDTH  instructions retired.
- busy  in  1  core busy; cycle counts only when high.

## Operation
- Read-only CSRs: WTID/LTID/LWID return wid. GTID/GWID return CORE_ID*NUM_WARPS+wid. GCID, NT, NW, NC, MISA, MVENDORID, MARCHID, MIMPID, CYCLE, CYCLE_H, INSTRET, INSTRET_H.
- Writable CSRs:
  - Per warp: FFLAGS, FRM, FCSR, MSCRATCH.
  - Shared: SATP, MSTATUS, MEDELEG, MIDELEG, MIE, MTVEC, MEPC, PMPCFG0, PMPADDR0, MCYCLE, MCYCLE_H, MINSTRET, MINSTRET_H.
- New value on accepted request:
  - RW: req_data.
  - RS: old | req_data.
  - RC: old & ~req_data.
  - Read: no write.
  - Field-narrow CSRs (FFLAGS 5b, FRM 3b, FCSR 8b) truncate.
- Illegal conditions, all with rsp_err=1, rsp_data=0 and no state change:
  - Unknown address, any op.
  - Read-only CSR with op RW.
  - Read-only CSR with op RS/RC and nonzero req_data.
- Read-only CSR with op RS/RC and zero req_data is a legal read.
- fflags merge, same cycle as a CSR write to FFLAGS/FCSR of the same warp: flags = written value | fpu_fflags. Different warp: both apply independently.
- cycle: +1 per clk while busy. instret: +cmt_size per cmt_valid. Both wrap modulo 2^CTR_WIDTH.
- Counter software write:
  - Replaces bits [31:0] (MCYCLE/MINSTRET) or bits [CTR_WIDTH-1:32] (`_H`).
  - Suppresses that counter's increment that cycle.
- `_H` reads return bits [CTR_WIDTH-1:32] zero-extended; 0 when CTR_WIDTH=32. `_H` writes are ignored when CTR_WIDTH=32 (no error).

## Timing
- Latency 1: a request accepted at edge N drives rsp_* from edge N.
- rsp_data samples state before the same edge's write.
- req_ready = ~rsp_valid | rsp_ready (one-entry skid-free output register). Full throughput of 1 req/cycle.
- rsp_* hold stable while rsp_valid & ~rsp_ready.
- Back-to-back RMW on the same CSR: the second request sees the first's result.
- Reset (async assert, sync deassert) clears:
  - All CSRs, counters, fcsr and snapshots to 0.
  - rsp_valid=0, rsp_err=0, rsp_data=0, rsp_wid=0.
- fpu_frm after reset is 0.
- Reset mid-transaction drops the pending response.

## Configuration
- CSR_CTR_SNAPSHOT_EN defined:
  - Reading CYCLE or INSTRET latches that counter's upper bits into a per-warp snapshot.
  - A later CYCLE_H/INSTRET_H read by that warp returns the snapshot, giving a coherent 64-bit read across a low-half wrap.
  - Snapshots reset to 0.
- Undefined: `_H` reads return live upper bits, and no snapshot registers exist.

## Test plan
- Reset, then read NW, GWID (wid 2, CORE_ID=1, NUM_WARPS=4) and MISA -> rsp 1 cycle later: `NUM_WARPS, 6, `ISA_CODE; rsp_err=0.
- MSTATUS RW 0xF0, RS 0x0F, RC 0x30 -> rsp_data 0, 0xF0, 0xFF; final read 0xCF.
- Same cycle: CSR RW FFLAGS=0x01 on warp 1 and fpu_fflags=0x04 on warp 1 -> next FFLAGS read on warp 1 = 0x05; warp 0 stays 0.
- RW to NT -> rsp_err=1, data 0. RS to NT with req_data 0 -> `NUM_THREADS, err 0. Read 0x7FF -> err 1.
- CTR_WIDTH=64: write MCYCLE=0xFFFFFFFF, MCYCLE_H=0, busy=1 -> low half wraps and CYCLE_H reads 1. With CSR_CTR_SNAPSHOT_EN: CYCLE read before the wrap pairs with CYCLE_H=0.
- rsp_ready held low 3 cycles with req_valid high -> req_ready=0, rsp_data stable, no request lost; 5 back-to-back cmt_valid size 4 -> INSTRET 20.

Source files
------------

// File: rtl/vx_csr_bank.sv
// Per-core CSR bank: per-warp fcsr/mscratch, shared machine CSRs and cycle/instret counters, single-cycle RMW.
// Optional macro CSR_CTR_SNAPSHOT_EN adds per-warp upper-half counter snapshots for coherent 64-bit reads.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NUM_CORES
`define NUM_CORES 1
`endif
`ifndef CSR_ADDR_BITS
`define CSR_ADDR_BITS 12
`endif
`ifndef FFG_BITS
`define FFG_BITS 5
`endif
`ifndef FRM_BITS
`define FRM_BITS 3
`endif
`ifndef ISA_CODE
`define ISA_CODE 32'h4000_1129
`endif

module vx_csr_bank #(
  parameter int CORE_ID   = 0,
  parameter int NUM_WARPS = `NUM_WARPS,
  parameter int CTR_WIDTH = 64,
  parameter int CMT_WIDTH = $clog2(`NUM_THREADS + 1),
  localparam int NWB      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NWB-1:0]            req_wid,
  input  logic [`CSR_ADDR_BITS-1:0] req_addr,
  input  logic [1:0]                req_op,
  input  logic [31:0]               req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [NWB-1:0]            rsp_wid,
  output logic [31:0]               rsp_data,
  output logic                      rsp_err,
  input  logic                      fpu_wr_valid,
  input  logic [NWB-1:0]            fpu_wr_wid,
  input  logic [`FFG_BITS-1:0]      fpu_fflags,
  input  logic [NWB-1:0]            fpu_rd_wid,
  output logic [`FRM_BITS-1:0]      fpu_frm,
  input  logic                      cmt_valid,
  input  logic [CMT_WIDTH-1:0]      cmt_size,
  input  logic                      busy
);
  localparam int FFG    = `FFG_BITS;
  localparam int FRM    = `FRM_BITS;
  localparam int FCSR_W = FFG + FRM;
  localparam int NMREG  = 9;
  localparam logic [CTR_WIDTH-1:0] LO_MASK = CTR_WIDTH'(32'hFFFF_FFFF);

  typedef logic [`CSR_ADDR_BITS-1:0] addr_t;
  localparam addr_t A_FFLAGS = 'h001, A_FRM = 'h002, A_FCSR = 'h003;
  localparam addr_t A_SATP = 'h180, A_MSTATUS = 'h300, A_MISA = 'h301, A_MEDELEG = 'h302;
  localparam addr_t A_MIDELEG = 'h303, A_MIE = 'h304, A_MTVEC = 'h305, A_MSCRATCH = 'h340;
  localparam addr_t A_MEPC = 'h341, A_PMPCFG0 = 'h3A0, A_PMPADDR0 = 'h3B0;
  localparam addr_t A_MCYCLE = 'hB00, A_MINSTRET = 'hB02, A_MCYCLE_H = 'hB80, A_MINSTRET_H = 'hB82;
  localparam addr_t A_CYCLE = 'hC00, A_INSTRET = 'hC02, A_CYCLE_H = 'hC80, A_INSTRET_H = 'hC82;
  localparam addr_t A_WTID = 'hCC0, A_LTID = 'hCC1, A_LWID = 'hCC2, A_GTID = 'hCC3;
  localparam addr_t A_GWID = 'hCC4, A_GCID = 'hCC5;
  localparam addr_t A_NT = 'hFC0, A_NW = 'hFC1, A_NC = 'hFC2;
  localparam addr_t A_MVENDORID = 'hF11, A_MARCHID = 'hF12, A_MIMPID = 'hF13;

  localparam logic [1:0] OP_READ = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;

  logic [FCSR_W-1:0]    fcsr_q [NUM_WARPS];
  logic [FCSR_W-1:0]    fcsr_d [NUM_WARPS];
  logic [31:0]          mscratch_q [NUM_WARPS];
  logic [31:0]          mscratch_d [NUM_WARPS];
  logic [31:0]          mreg_q [NMREG];
  logic [31:0]          mreg_d [NMREG];
  logic [CTR_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic                 rsp_valid_q, rsp_err_q;
  logic [NWB-1:0]       rsp_wid_q;
  logic [31:0]          rsp_data_q;

  logic        accept, known, read_only, err, wr_en, rd_ok, mreg_hit;
  logic [3:0]  mreg_idx;
  logic [31:0] old_val, new_val, cycle_hi, instret_hi, cycle_hi_rd, instret_hi_rd;

  // Handshake: a request transfers on a clock edge where req_valid & req_ready; a response
  // transfers where rsp_valid & rsp_ready, and rsp_* hold steady until then.
  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;

  assign cycle_hi   = 32'(cycle_q >> 32);
  assign instret_hi = 32'(instret_q >> 32);

`ifdef CSR_CTR_SNAPSHOT_EN
  logic [31:0] cyc_snap_q [NUM_WARPS];
  logic [31:0] ins_snap_q [NUM_WARPS];
  assign cycle_hi_rd   = cyc_snap_q[req_wid];
  assign instret_hi_rd = ins_snap_q[req_wid];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        cyc_snap_q[w] <= '0;
        ins_snap_q[w] <= '0;
      end
    end else if (rd_ok) begin
      if (req_addr == A_CYCLE)   cyc_snap_q[req_wid] <= cycle_hi;
      if (req_addr == A_INSTRET) ins_snap_q[req_wid] <= instret_hi;
    end
  end
`else
  assign cycle_hi_rd   = cycle_hi;
  assign instret_hi_rd = instret_hi;
`endif

  always_comb begin
    old_val   = '0;
    known     = 1'b1;
    read_only = 1'b0;
    mreg_hit  = 1'b0;
    mreg_idx  = '0;
    case (req_addr)
      A_FFLAGS:     old_val = 32'(fcsr_q[req_wid][FFG-1:0]);
      A_FRM:        old_val = 32'(fcsr_q[req_wid][FCSR_W-1:FFG]);
      A_FCSR:       old_val = 32'(fcsr_q[req_wid]);
      A_MSCRATCH:   old_val = mscratch_q[req_wid];
      A_SATP:       begin mreg_hit = 1'b1; mreg_idx = 4'd0; end
      A_MSTATUS:    begin mreg_hit = 1'b1; mreg_idx = 4'd1; end
      A_MEDELEG:    begin mreg_hit = 1'b1; mreg_idx = 4'd2; end
      A_MIDELEG:    begin mreg_hit = 1'b1; mreg_idx = 4'd3; end
      A_MIE:        begin mreg_hit = 1'b1; mreg_idx = 4'd4; end
      A_MTVEC:      begin mreg_hit = 1'b1; mreg_idx = 4'd5; end
      A_MEPC:       begin mreg_hit = 1'b1; mreg_idx = 4'd6; end
      A_PMPCFG0:    begin mreg_hit = 1'b1; mreg_idx = 4'd7; end
      A_PMPADDR0:   begin mreg_hit = 1'b1; mreg_idx = 4'd8; end
      A_MCYCLE:     old_val = cycle_q[31:0];
      A_MCYCLE_H:   old_val = cycle_hi;
      A_MINSTRET:   old_val = instret_q[31:0];
      A_MINSTRET_H: old_val = instret_hi;
      A_CYCLE:      begin read_only = 1'b1; old_val = cycle_q[31:0]; end
      A_CYCLE_H:    begin read_only = 1'b1; old_val = cycle_hi_rd; end
      A_INSTRET:    begin read_only = 1'b1; old_val = instret_q[31:0]; end
      A_INSTRET_H:  begin read_only = 1'b1; old_val = instret_hi_rd; end
      A_WTID, A_LTID, A_LWID: begin read_only = 1'b1; old_val = 32'(req_wid); end
      A_GTID, A_GWID: begin read_only = 1'b1; old_val = 32'(CORE_ID * NUM_WARPS) + 32'(req_wid); end
      A_GCID:       begin read_only = 1'b1; old_val = 32'(CORE_ID); end
      A_NT:         begin read_only = 1'b1; old_val = 32'(`NUM_THREADS); end
      A_NW:         begin read_only = 1'b1; old_val = 32'(NUM_WARPS); end
      A_NC:         begin read_only = 1'b1; old_val = 32'(`NUM_CORES); end
      A_MISA:       begin read_only = 1'b1; old_val = `ISA_CODE; end
      A_MVENDORID, A_MARCHID, A_MIMPID: read_only = 1'b1;
      default:      known = 1'b0;
    endcase
    if (mreg_hit) old_val = mreg_q[mreg_idx];
  end

  // Set/clear with a zero mask on a read-only CSR is an ordinary read.
  assign err   = ~known | (read_only & ((req_op == OP_RW) | (req_op[1] & (|req_data))));
  assign rd_ok = accept & ~err;
  assign wr_en = rd_ok & ~read_only & (req_op != OP_READ);

  always_comb begin
    case (req_op)
      OP_RW:   new_val = req_data;
      OP_RS:   new_val = old_val | req_data;
      OP_RC:   new_val = old_val & ~req_data;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    fcsr_d     = fcsr_q;
    mscratch_d = mscratch_q;
    mreg_d     = mreg_q;
    if (wr_en) begin
      case (req_addr)
        A_FFLAGS:   fcsr_d[req_wid][FFG-1:0] = new_val[FFG-1:0];
        A_FRM:      fcsr_d[req_wid][FCSR_W-1:FFG] = new_val[FRM-1:0];
        A_FCSR:     fcsr_d[req_wid] = new_val[FCSR_W-1:0];
        A_MSCRATCH: mscratch_d[req_wid] = new_val;
        default: ;
      endcase
      if (mreg_hit) mreg_d[mreg_idx] = new_val;
    end
    // FPU flags are ORed on top of any same-cycle software write so no flag is lost.
    if (fpu_wr_valid)
      fcsr_d[fpu_wr_wid][FFG-1:0] = fcsr_d[fpu_wr_wid][FFG-1:0] | fpu_fflags;
  end

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (wr_en && req_addr == A_MCYCLE)
      cycle_d = (cycle_q & ~LO_MASK) | CTR_WIDTH'(new_val);
    else if (wr_en && req_addr == A_MCYCLE_H && CTR_WIDTH > 32)
      cycle_d = (cycle_q & LO_MASK) | (CTR_WIDTH'(new_val) << 32);
    else if (busy)
      cycle_d = cycle_q + CTR_WIDTH'(1);
    if (wr_en && req_addr == A_MINSTRET)
      instret_d = (instret_q & ~LO_MASK) | CTR_WIDTH'(new_val);
    else if (wr_en && req_addr == A_MINSTRET_H && CTR_WIDTH > 32)
      instret_d = (instret_q & LO_MASK) | (CTR_WIDTH'(new_val) << 32);
    else if (cmt_valid)
      instret_d = instret_q + CTR_WIDTH'(cmt_size);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        fcsr_q[w]     <= '0;
        mscratch_q[w] <= '0;
      end
      for (int i = 0; i < NMREG; i++) mreg_q[i] <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_wid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      fcsr_q     <= fcsr_d;
      mscratch_q <= mscratch_d;
      mreg_q     <= mreg_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err;
        rsp_wid_q   <= req_wid;
        rsp_data_q  <= err ? 32'd0 : old_val;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_wid   = rsp_wid_q;
  assign rsp_data  = rsp_data_q;
  assign fpu_frm   = fcsr_q[fpu_rd_wid][FCSR_W-1:FFG];

endmodule

// File: tb/tb_vx_csr_bank.sv
// Self-checking bench for vx_csr_bank: scenario tasks drive requests, a scoreboard queue checks responses.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef ISA_CODE
`define ISA_CODE 32'h4000_1129
`endif

module tb_vx_csr_bank;
  localparam int NWB = 2;
  localparam int EW  = 1 + NWB + 32;

  localparam logic [11:0] A_FFLAGS = 12'h001, A_FRM = 12'h002, A_FCSR = 12'h003;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MCYCLE_H = 12'hB80;
  localparam logic [11:0] A_CYCLE = 12'hC00, A_INSTRET = 12'hC02, A_CYCLE_H = 12'hC80, A_INSTRET_H = 12'hC82;
  localparam logic [11:0] A_WTID = 12'hCC0, A_GWID = 12'hCC4, A_GCID = 12'hCC5;
  localparam logic [11:0] A_NT = 12'hFC0, A_NW = 12'hFC1, A_BAD = 12'h7FF;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid = 1'b0, req_ready;
  logic [NWB-1:0] req_wid = '0;
  logic [11:0]    req_addr = '0;
  logic [1:0]     req_op = '0;
  logic [31:0]    req_data = '0;
  logic           rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [NWB-1:0] rsp_wid;
  logic [31:0]    rsp_data;
  logic           fpu_wr_valid = 1'b0;
  logic [NWB-1:0] fpu_wr_wid = '0, fpu_rd_wid = '0;
  logic [4:0]     fpu_fflags = '0;
  logic [2:0]     fpu_frm;
  logic           cmt_valid = 1'b0;
  logic [2:0]     cmt_size = '0;
  logic           busy = 1'b0;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  vx_csr_bank #(.CORE_ID(1), .NUM_WARPS(4), .CTR_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fpu_wr_valid(fpu_wr_valid), .fpu_wr_wid(fpu_wr_wid), .fpu_fflags(fpu_fflags),
    .fpu_rd_wid(fpu_rd_wid), .fpu_frm(fpu_frm),
    .cmt_valid(cmt_valid), .cmt_size(cmt_size), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d responses outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // scoreboard: a response transfers on the next edge when valid & ready are seen at the negedge
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got err=%0b wid=%0d data=%h, required no response",
                 rsp_err, rsp_wid, rsp_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({rsp_err, rsp_wid, rsp_data} !== e)
          $display("FAIL rsp_data: got err=%0b wid=%0d data=%h, required err=%0b wid=%0d data=%h",
                   rsp_err, rsp_wid, rsp_data, e[EW-1], e[EW-2 -: NWB], e[31:0]);
        else passes++;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [NWB-1:0] wid, input logic [11:0] addr, input logic [1:0] op,
                      input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err);
    logic rdy;
    int   guard;
    req_valid = 1'b1;
    req_wid   = wid;
    req_addr  = addr;
    req_op    = op;
    req_data  = data;
    guard     = 0;
    rdy       = 1'b0;
    while (!rdy && guard < 50) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!rdy) begin
      checks++;
      $display("FAIL req_accept_timeout: addr=%h not accepted, required acceptance within 50 cycles", addr);
    end else begin
      exp_q.push_back({exp_err, wid, exp_data});
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    idle();
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    else passes++;
  endtask

  // scenario tasks
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_wid, rsp_data} !== '0)
      $display("FAIL reset_rsp: got valid=%0b err=%0b wid=%0d data=%h, required all 0",
               rsp_valid, rsp_err, rsp_wid, rsp_data);
    else passes++;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b required 1", req_ready);
    else passes++;
    checks++;
    if (fpu_frm !== 3'd0) $display("FAIL reset_frm: got %0d required 0", fpu_frm);
    else passes++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ro_ids();
    send(2'd0, A_NW,   2'd0, 32'd0, 32'(`NUM_WARPS), 1'b0);
    send(2'd2, A_GWID, 2'd0, 32'd0, 32'd6, 1'b0);
    send(2'd0, A_MISA, 2'd0, 32'd0, `ISA_CODE, 1'b0);
    send(2'd3, A_WTID, 2'd0, 32'd0, 32'd3, 1'b0);
    send(2'd1, A_GCID, 2'd0, 32'd0, 32'd1, 1'b0);
    drain();
  endtask

  task automatic test_rmw();
    send(2'd0, A_MSTATUS, 2'd1, 32'hF0, 32'h00, 1'b0);
    send(2'd0, A_MSTATUS, 2'd2, 32'h0F, 32'hF0, 1'b0);
    send(2'd0, A_MSTATUS, 2'd3, 32'h30, 32'hFF, 1'b0);
    send(2'd0, A_MSTATUS, 2'd0, 32'h00, 32'hCF, 1'b0);
    send(2'd0, A_MSCRATCH, 2'd1, 32'hDEAD_BEEF, 32'd0, 1'b0);
    send(2'd1, A_MSCRATCH, 2'd0, 32'd0, 32'd0, 1'b0);
    send(2'd0, A_MSCRATCH, 2'd0, 32'd0, 32'hDEAD_BEEF, 1'b0);
    drain();
  endtask

  task automatic test_fflags_merge();
    fpu_wr_valid = 1'b1; fpu_wr_wid = 2'd1; fpu_fflags = 5'h04;
    send(2'd1, A_FFLAGS, 2'd1, 32'h01, 32'h00, 1'b0);
    fpu_wr_valid = 1'b1; fpu_wr_wid = 2'd3; fpu_fflags = 5'h08;
    send(2'd2, A_FFLAGS, 2'd1, 32'h22, 32'h00, 1'b0);
    fpu_wr_valid = 1'b0;
    send(2'd1, A_FFLAGS, 2'd0, 32'd0, 32'h05, 1'b0);
    send(2'd0, A_FFLAGS, 2'd0, 32'd0, 32'h00, 1'b0);
    send(2'd2, A_FFLAGS, 2'd0, 32'd0, 32'h02, 1'b0);
    send(2'd3, A_FFLAGS, 2'd0, 32'd0, 32'h08, 1'b0);
    drain();
  endtask

  task automatic test_frm();
    send(2'd1, A_FRM, 2'd1, 32'hFF, 32'h0, 1'b0);
    idle();
    fpu_rd_wid = 2'd1;
    @(negedge clk);
    checks++;
    if (fpu_frm !== 3'd7) $display("FAIL frm_w1: got %0d required 7", fpu_frm);
    else passes++;
    fpu_rd_wid = 2'd0;
    #1;
    checks++;
    if (fpu_frm !== 3'd0) $display("FAIL frm_w0: got %0d required 0", fpu_frm);
    else passes++;
    @(posedge clk);
    #1;
    send(2'd1, A_FCSR, 2'd0, 32'd0, 32'hE5, 1'b0);
    drain();
  endtask

  task automatic test_illegal();
    send(2'd0, A_NT,      2'd1, 32'h1, 32'd0, 1'b1);
    send(2'd0, A_NT,      2'd2, 32'h0, 32'(`NUM_THREADS), 1'b0);
    send(2'd0, A_NT,      2'd2, 32'h5, 32'd0, 1'b1);
    send(2'd0, A_BAD,     2'd0, 32'h0, 32'd0, 1'b1);
    send(2'd0, A_MISA,    2'd3, 32'h1, 32'd0, 1'b1);
    send(2'd0, A_CYCLE,   2'd1, 32'h9, 32'd0, 1'b1);
    send(2'd0, A_MSTATUS, 2'd0, 32'h0, 32'hCF, 1'b0);
    drain();
  endtask

  task automatic test_cycle_wrap();
    logic [31:0] exp_hi;
`ifdef CSR_CTR_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    busy = 1'b0;
    send(2'd2, A_MCYCLE_H, 2'd1, 32'h0, 32'h0, 1'b0);
    send(2'd2, A_MCYCLE,   2'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    busy = 1'b1;
    send(2'd2, A_CYCLE,    2'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    send(2'd2, A_CYCLE_H,  2'd0, 32'h0, exp_hi, 1'b0);
    busy = 1'b0;
    send(2'd2, A_MCYCLE_H, 2'd0, 32'h0, 32'h1, 1'b0);
    send(2'd2, A_MCYCLE,   2'd0, 32'h0, 32'h1, 1'b0);
    drain();
  endtask

  task automatic test_instret();
    cmt_valid = 1'b1;
    cmt_size  = 3'd4;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    cmt_valid = 1'b0;
    send(2'd0, A_INSTRET,   2'd0, 32'h0, 32'd20, 1'b0);
    send(2'd0, A_INSTRET_H, 2'd0, 32'h0, 32'd0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    send(2'd0, A_MSTATUS, 2'd0, 32'h0, 32'hCF, 1'b0);
    req_wid = 2'd1; req_addr = A_MSCRATCH; req_op = 2'd1; req_data = 32'h1234;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hCF)
        $display("FAIL stall_%0d: got ready=%0b valid=%0b data=%h, required ready=0 valid=1 data=000000cf",
                 i, req_ready, rsp_valid, rsp_data);
      else passes++;
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    send(2'd1, A_MSCRATCH, 2'd1, 32'h1234, 32'h0, 1'b0);
    send(2'd1, A_MSCRATCH, 2'd0, 32'h0, 32'h1234, 1'b0);
    send(2'd0, A_MSCRATCH, 2'd0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drain();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    send(2'd0, A_MSTATUS, 2'd0, 32'h0, 32'hCF, 1'b0);
    idle();
    #2;
    checks++;
    if (rsp_valid !== 1'b1) $display("FAIL pending_before_reset: got valid=%0b required 1", rsp_valid);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0)
      $display("FAIL reset_drop: got valid=%0b data=%h, required valid=0 data=0", rsp_valid, rsp_data);
    else passes++;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    fpu_rd_wid = 2'd1;
    @(negedge clk);
    checks++;
    if (fpu_frm !== 3'd0) $display("FAIL frm_after_reset: got %0d required 0", fpu_frm);
    else passes++;
    @(posedge clk);
    #1;
    send(2'd0, A_MSTATUS,  2'd0, 32'h0, 32'h0, 1'b0);
    send(2'd1, A_FCSR,     2'd0, 32'h0, 32'h0, 1'b0);
    send(2'd1, A_MSCRATCH, 2'd0, 32'h0, 32'h0, 1'b0);
    send(2'd0, A_MCYCLE_H, 2'd0, 32'h0, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_ro_ids();
    test_rmw();
    test_fflags_merge();
    test_frm();
    test_illegal();
    test_cycle_wrap();
    test_instret();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
